door_access_scheduler: RTL and testbench

DOOR_ACCESS_SCHEDULER -- requirements
Module: door_access_scheduler

---
 rtl/door_access_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_door_access_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/door_access_scheduler.sv
// Door access scheduler: round-robin grant of one door among NPANEL keypads,
// code entry checking, door/alarm hold timers and lockout after repeated failures.
module door_access_scheduler #(
  parameter int NPANEL       = 4,
  parameter int DOOR_CYCLES  = 16,
  parameter int ALARM_CYCLES = 8,
  parameter int KEY_TIMEOUT  = 32,
  parameter int MAX_FAILS    = 3
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  day,
  input  logic [NPANEL-1:0]     req,
  input  logic [NPANEL-1:0]     key_vld,
  input  logic [4*NPANEL-1:0]   key,
  output logic [NPANEL-1:0]     gnt,
  output logic                  door_open,
  output logic                  alarm,
  output logic                  lockout,
  output logic                  busy
);

  localparam int PW   = (NPANEL > 1) ? $clog2(NPANEL) : 1;
  localparam int T1   = (DOOR_CYCLES > ALARM_CYCLES) ? DOOR_CYCLES : ALARM_CYCLES;
  localparam int TMAX = (T1 > KEY_TIMEOUT) ? T1 : KEY_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, OPEN, ALARM, LOCKED} state_t;

  state_t            state_q;
  logic [NPANEL-1:0] gnt_q;
  logic [PW-1:0]     gidx_q, last_q;
  logic              night_q, mism_q, day_q;
  logic [2:0]        idx_q;
  logic [CW-1:0]     cnt_q;
  logic [FW-1:0]     fail_q;
  logic              door_q, alarm_q, lock_q, busy_q;

  logic              found_d;
  logic [PW-1:0]     sel_d, pos_c;
  logic              kv_c, mism_c, last_key_c;
  logic [3:0]        kd_c;

  function automatic logic [3:0] exp_digit(input logic night, input logic [2:0] i);
    if (!night) return 4'h1;
    case (i)
      3'd0:    return 4'h5;
      3'd1:    return 4'h3;
      3'd2:    return 4'hA;
      3'd3:    return 4'h1;
      default: return 4'h7;
    endcase
  endfunction

  // Search starts one past the last granted panel and wraps around.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    pos_c   = '0;
    for (int i = 1; i <= NPANEL; i++) begin
      pos_c = PW'((int'(last_q) + i) % NPANEL);
      if (!found_d && req[pos_c]) begin
        found_d = 1'b1;
        sel_d   = pos_c;
      end
    end
  end

  always_comb begin
    kv_c       = key_vld[gidx_q];
    kd_c       = key[{gidx_q, 2'b00} +: 4];
    mism_c     = mism_q | (kd_c != exp_digit(night_q, idx_q));
    last_key_c = (idx_q == (night_q ? 3'd4 : 3'd3));
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= PW'(NPANEL - 1);
      night_q <= 1'b0;
      mism_q  <= 1'b0;
      day_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      door_q  <= 1'b0;
      alarm_q <= 1'b0;
      lock_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      day_q <= day;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= COLLECT;
            gnt_q   <= NPANEL'(1) << sel_d;
            gidx_q  <= sel_d;
            last_q  <= sel_d;
            night_q <= ~day;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        // Priority: request withdrawn, then key, then timeout.
        COLLECT: begin
          if (!req[gidx_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (kv_c) begin
            cnt_q  <= '0;
            idx_q  <= idx_q + 3'd1;
            mism_q <= mism_c;
            if (last_key_c) begin
              gnt_q <= '0;
              if (mism_c) begin
                state_q <= ALARM;
                alarm_q <= 1'b1;
                fail_q  <= (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
              end else begin
                state_q <= OPEN;
                door_q  <= 1'b1;
              end
            end
          end else if (cnt_q == CW'(KEY_TIMEOUT - 1)) begin
            state_q <= ALARM;
            gnt_q   <= '0;
            cnt_q   <= '0;
            alarm_q <= 1'b1;
            fail_q  <= (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        OPEN: begin
          if (cnt_q == CW'(DOOR_CYCLES - 1)) begin
            state_q <= IDLE;
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
            fail_q  <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ALARM: begin
          if (cnt_q == CW'(ALARM_CYCLES - 1)) begin
            alarm_q <= 1'b0;
            cnt_q   <= '0;
            if (fail_q == FW'(MAX_FAILS)) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          if (day && !day_q) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
            fail_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          door_q  <= 1'b0;
          alarm_q <= 1'b0;
          lock_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign door_open = door_q;
  assign alarm     = alarm_q;
  assign lockout   = lock_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_door_access_scheduler.sv
// Directed bench for door_access_scheduler with hand-computed expectations.
module tb_door_access_scheduler;

  logic        clk = 1'b0;
  logic        RESET;
  logic        day;
  logic [3:0]  req, key_vld, gnt;
  logic [15:0] key;
  logic        door_open, alarm, lockout, busy;

  int errors = 0;
  int checks = 0;

  door_access_scheduler dut (
    .clk(clk), .RESET(RESET), .day(day), .req(req), .key_vld(key_vld), .key(key),
    .gnt(gnt), .door_open(door_open), .alarm(alarm), .lockout(lockout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int p, input logic [3:0] k);
    key_vld = 4'(1) << p;
    key     = 16'(k) << (4 * p);
    tick();
    key_vld = '0;
    key     = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Grant panel p, enter n digits (msb-first in code), then withdraw the request.
  task automatic session(input int p, input logic [19:0] code, input int n);
    req = 4'(1) << p;
    tick();
    for (int i = 0; i < n; i++) press(p, code[19 - 4 * i -: 4]);
    req = '0;
  endtask

  int n_on;
  int door_seen;

  initial begin
    RESET = 1'b1; day = 1'b1; req = '0; key_vld = '0; key = '0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_door", 32'(door_open), 32'h0);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_lock", 32'(lockout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    RESET = 1'b0;

    // Day code 1,1,1,1 on panel 0 opens the door for 16 cycles.
    req = 4'b0001;
    tick();
    check("open_gnt", 32'(gnt), 32'h1);
    check("open_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) press(0, 4'h1);
    check("open_door_early", 32'(door_open), 32'h0);
    press(0, 4'h1);
    req = '0;
    check("open_door_first", 32'(door_open), 32'h1);
    check("open_gnt_off", 32'(gnt), 32'h0);
    n_on = 1;
    repeat (20) begin
      tick();
      if (door_open) n_on++;
    end
    check("open_door_len", 32'(n_on), 32'd16);
    check("open_idle_busy", 32'(busy), 32'h0);

    // Round-robin over four aborted sessions; key in the abort cycle is ignored.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      req = 4'b1111;
      tick();
      check("rr_gnt", 32'(gnt), 32'(4'(1) << s));
      req = '0;
      if (s == 1) begin
        key_vld = 4'b0010;
        key     = 16'h0010;
      end
      tick();
      key_vld = '0;
      key = '0;
      check("rr_abort_gnt", 32'(gnt), 32'h0);
      check("rr_abort_alarm", 32'(alarm | door_open), 32'h0);
    end

    // Night code with wrong 4th digit on panel 2; day toggle mid-entry ignored.
    day = 1'b0;
    req = 4'b0100;
    tick();
    check("night_gnt", 32'(gnt), 32'h4);
    press(2, 4'h5);
    press(2, 4'h3);
    day = 1'b1;
    press(2, 4'hA);
    press(2, 4'h2);
    check("night_no_early_alarm", 32'(alarm), 32'h0);
    check("night_still_gnt", 32'(gnt), 32'h4);
    press(2, 4'h7);
    req = '0;
    day = 1'b0;
    check("night_alarm", 32'(alarm), 32'h1);
    n_on = 1;
    door_seen = 0;
    repeat (12) begin
      tick();
      if (alarm) n_on++;
      if (door_open) door_seen++;
    end
    check("night_alarm_len", 32'(n_on), 32'd8);
    check("night_no_door", 32'(door_seen), 32'd0);
    check("night_idle", 32'(busy), 32'h0);

    // Two more failures reach the lockout threshold.
    session(0, 20'h00000, 5);
    check("fail2_alarm", 32'(alarm), 32'h1);
    repeat (8) tick();
    check("fail2_no_lock", 32'(lockout), 32'h0);
    check("fail2_idle", 32'(busy), 32'h0);
    session(1, 20'h00000, 5);
    check("fail3_alarm", 32'(alarm), 32'h1);
    repeat (8) tick();
    check("fail3_lock", 32'(lockout), 32'h1);
    check("fail3_alarm_off", 32'(alarm), 32'h0);
    req = 4'b1111;
    repeat (3) tick();
    check("lock_gnt", 32'(gnt), 32'h0);
    check("lock_busy", 32'(busy), 32'h1);
    check("lock_hold", 32'(lockout), 32'h1);
    day = 1'b1;
    tick();
    req = '0;
    check("unlock_lock", 32'(lockout), 32'h0);
    check("unlock_busy", 32'(busy), 32'h0);

    // Failure counter was cleared: one wrong session must not lock again.
    tick();
    session(3, 20'h22220, 4);
    check("post_unlock_alarm", 32'(alarm), 32'h1);
    repeat (8) tick();
    check("post_unlock_no_lock", 32'(lockout), 32'h0);
    check("post_unlock_idle", 32'(busy), 32'h0);

    // Timeout after two keys; valid day keys on other panels are ignored.
    req = 4'b0010;
    tick();
    check("to_gnt", 32'(gnt), 32'h2);
    press(1, 4'h1);
    press(1, 4'h1);
    key_vld = 4'b1101;
    key     = 16'h1101;
    repeat (31) tick();
    check("to_no_alarm_yet", 32'(alarm), 32'h0);
    check("to_no_door", 32'(door_open), 32'h0);
    check("to_gnt_held", 32'(gnt), 32'h2);
    tick();
    check("to_alarm", 32'(alarm), 32'h1);
    check("to_gnt_off", 32'(gnt), 32'h0);
    key_vld = '0;
    key = '0;
    req = '0;
    repeat (8) tick();
    check("to_idle", 32'(busy), 32'h0);

    // Reset in the middle of OPEN.
    do_reset();
    session(0, 20'h11110, 4);
    check("rst_open_door", 32'(door_open), 32'h1);
    repeat (5) tick();
    check("rst_open_door_c5", 32'(door_open), 32'h1);
    RESET = 1'b1;
    #1;
    check("rst_async_door", 32'(door_open), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    tick();
    RESET = 1'b0;
    tick();
    check("rst_after_door", 32'(door_open), 32'h0);
    check("rst_after_alarm", 32'(alarm), 32'h0);
    check("rst_after_busy", 32'(busy), 32'h0);
    req = 4'b1111;
    tick();
    check("rst_rr_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
